bram_stream_rd: RTL and testbench

BRAM_STREAM_RD -- requirements
Module: bram_stream_rd

---
 rtl/bram_stream_rd_if.sv | 24 ++
 rtl/bram_stream_rd.sv | 126 ++++++++++++
 tb/tb_bram_stream_rd.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_stream_rd_if.sv
// BRAM read port plus valid/ready output stream used by bram_stream_rd.
// master = streaming reader side, slave = memory/sink side.
interface bram_stream_rd_if #(
    parameter int WIDTH = 128,
    parameter int ADDR  = 10
);
    logic             mem_en;
    logic [ADDR-1:0]  mem_addr;
    logic [WIDTH-1:0] mem_dout;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    modport master (
        output mem_en, mem_addr, m_valid, m_data, m_last,
        input  mem_dout, m_ready
    );

    modport slave (
        input  mem_en, mem_addr, m_valid, m_data, m_last,
        output mem_dout, m_ready
    );
endinterface

// File: rtl/bram_stream_rd.sv
// Reads a burst of len words from a 1-cycle-latency BRAM and streams them out through a 2-entry FIFO.
// Optional macro BRAM_STREAM_RD_STRIDE_EN adds a stride port; without it addresses advance by 1.
module bram_stream_rd #(
    parameter int WIDTH = 128,
    parameter int ADDR  = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [ADDR-1:0] base_addr,
    input  logic [ADDR:0]   len,
`ifdef BRAM_STREAM_RD_STRIDE_EN
    input  logic [ADDR-1:0] stride,
`endif
    output logic            busy,
    output logic            done,
    bram_stream_rd_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    localparam logic [ADDR:0] CNT_ONE = (ADDR+1)'(1);

    state_e           state_q, state_d;
    logic [ADDR-1:0]  addr_q, addr_d;
    logic [ADDR-1:0]  step_q, step_d, step_in;
    logic [ADDR:0]    reads_left_q, reads_left_d;
    logic [ADDR:0]    beats_left_q, beats_left_d;
    logic             inflight_q;
    logic [WIDTH-1:0] fifo_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       count_q, count_d;
    logic             done_q, done_d;
    logic             valid, pop, issue, last_beat, last_pop;

`ifdef BRAM_STREAM_RD_STRIDE_EN
    assign step_in = stride;
`else
    assign step_in = ADDR'(1);
`endif

    assign valid     = (count_q != 2'd0);
    assign pop       = valid & bus.m_ready;
    assign last_beat = valid && (beats_left_q == CNT_ONE);
    assign last_pop  = pop && last_beat;
    // A read is issued only if its returning word is guaranteed a FIFO slot, crediting this cycle's pop.
    assign issue = (state_q == RUN) &&
                   (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            step_q       <= '0;
            reads_left_q <= '0;
            beats_left_q <= '0;
            inflight_q   <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) fifo_q[i] <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            step_q       <= step_d;
            reads_left_q <= reads_left_d;
            beats_left_q <= beats_left_d;
            inflight_q   <= issue;
            count_q      <= count_d;
            done_q       <= done_d;
            if (inflight_q) begin
                fifo_q[wr_ptr_q] <= bus.mem_dout;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        step_d       = step_q;
        reads_left_d = reads_left_q;
        beats_left_d = beats_left_q;
        count_d      = count_q + {1'b0, inflight_q} - {1'b0, pop};
        done_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d       = base_addr;
                    step_d       = step_in;
                    reads_left_d = len;
                    beats_left_d = len;
                    if (len == '0) done_d  = 1'b1;
                    else           state_d = RUN;
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d       = addr_q + step_q;
                    reads_left_d = reads_left_q - CNT_ONE;
                    if (reads_left_q == CNT_ONE) state_d = DRAIN;
                end
                if (pop) beats_left_d = beats_left_q - CNT_ONE;
            end
            DRAIN: begin
                if (pop) beats_left_d = beats_left_q - CNT_ONE;
                if (last_pop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != IDLE);
        done         = done_q;
        bus.mem_en   = issue;
        bus.mem_addr = issue ? addr_q : '0;
        bus.m_valid  = valid;
        bus.m_data   = fifo_q[rd_ptr_q];
        bus.m_last   = last_beat;
    end
endmodule

// File: tb/tb_bram_stream_rd.sv
// Bench for bram_stream_rd: directed table, stall/reset sequences and random bursts vs a queue-based model.
module tb_bram_stream_rd;
    localparam int WIDTH = 128;
    localparam int ADDR  = 10;
    localparam int DEPTH = 1 << ADDR;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [ADDR-1:0] base_addr = '0;
    logic [ADDR:0]   len = '0;
`ifdef BRAM_STREAM_RD_STRIDE_EN
    logic [ADDR-1:0] stride = ADDR'(1);
`endif
    logic            busy, done;

    bram_stream_rd_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();

    bram_stream_rd #(.WIDTH(WIDTH), .ADDR(ADDR)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
`ifdef BRAM_STREAM_RD_STRIDE_EN
        .stride    (stride),
`endif
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM with one cycle read latency; junk on the bus when not enabled.
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk)
        bus.mem_dout <= bus.mem_en ? mem[bus.mem_addr] : {$urandom, $urandom, $urandom, $urandom};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    // m_ready driver: 0 = always high, 1 = pattern 1,0,0,1, 2 = random
    int rmode = 0;
    int ph = 0;
    logic [3:0] pat = 4'b1001;
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0:       bus.m_ready = 1'b1;
                1:       begin bus.m_ready = pat[ph % 4]; ph++; end
                default: bus.m_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (rmode != 1) ph = 0;
        end
    end

    typedef struct { logic [WIDTH-1:0] data; logic last; } beat_t;
    beat_t           exp_beat[$];
    logic [ADDR-1:0] exp_addr[$];
    logic [ADDR-1:0] addr_log[$];
    int              beat_cyc[$];
    int              done_cyc[$];
    bit              busy_m = 0, done_m = 0, zero_chk = 0, stall_prev = 0, mon_en = 0;
    logic [WIDTH-1:0] prev_data;
    logic            prev_last;
    int              issued = 0, popped = 0;

    // Reference model: a burst accepted while idle expands into a list of addresses and beats.
    always @(negedge clk) if (mon_en) begin
        bit              hs, model_last;
        beat_t           b;
        int              step;
        logic [ADDR-1:0] a;
        hs = bus.m_valid && bus.m_ready;
        model_last = 0;
        chk("busy", busy, busy_m);
        chk("done", done, done_m);
        if (done) done_cyc.push_back(cyc);
        if (zero_chk) begin
            chk("rst_mem_en", bus.mem_en, 0);
            chk("rst_mem_addr", bus.mem_addr, 0);
            chk("rst_m_valid", bus.m_valid, 0);
            chk("rst_m_data", bus.m_data, 0);
            chk("rst_m_last", bus.m_last, 0);
            zero_chk = 0;
        end
        if (bus.mem_en) begin
            addr_log.push_back(bus.mem_addr);
            issued++;
            chk("read_expected", exp_addr.size() > 0, 1);
            if (exp_addr.size() > 0) chk("mem_addr", bus.mem_addr, exp_addr.pop_front());
        end else begin
            chk("idle_addr", bus.mem_addr, 0);
        end
        if (stall_prev) begin
            chk("hold_valid", bus.m_valid, 1);
            chk("hold_data", bus.m_data, prev_data);
            chk("hold_last", bus.m_last, prev_last);
        end
        if (hs) begin
            popped++;
            beat_cyc.push_back(cyc);
            chk("beat_expected", exp_beat.size() > 0, 1);
            if (exp_beat.size() > 0) begin
                b = exp_beat.pop_front();
                chk("m_data", bus.m_data, b.data);
                chk("m_last", bus.m_last, b.last);
                model_last = b.last;
            end
        end
        chk("outstanding_le2", (issued - popped) <= 2, 1);

        stall_prev = bus.m_valid && !bus.m_ready && !rst;
        prev_data  = bus.m_data;
        prev_last  = bus.m_last;
        if (rst) begin
            exp_beat.delete();
            exp_addr.delete();
            busy_m = 0; done_m = 0; zero_chk = 1;
            issued = 0; popped = 0;
        end else begin
            done_m = 0;
            if (!busy_m && start) begin
                if (len == 0) done_m = 1;
                else begin
`ifdef BRAM_STREAM_RD_STRIDE_EN
                    step = int'(stride);
`else
                    step = 1;
`endif
                    busy_m = 1;
                    for (int k = 0; k < int'(len); k++) begin
                        a = ADDR'(int'(base_addr) + k * step);
                        exp_addr.push_back(a);
                        b.data = mem[a];
                        b.last = (k == int'(len) - 1);
                        exp_beat.push_back(b);
                    end
                end
            end else if (model_last) begin
                busy_m = 0;
                done_m = 1;
            end
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(input int b, input int l, output int s);
        base_addr = ADDR'(b);
        len       = (ADDR+1)'(l);
        s         = cyc;
        start     = 1'b1;
        tick;
        start     = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy_m && n < budget) begin tick; n++; end
        chk("burst_completes", busy_m, 0);
    endtask

    task automatic clear_logs;
        addr_log.delete(); beat_cyc.delete(); done_cyc.delete();
    endtask

    typedef struct { int base; int len; int nbeats; int last_addr; int done_off; } vec_t;
    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s, s2;
        int b, l;
        logic [ADDR-1:0] want_addr [4];

        vecs[0] = '{4,    8,    8,    11,   11};
        vecs[1] = '{1020, 6,    6,    1,    9};
        vecs[2] = '{0,    0,    0,    0,    1};
        vecs[3] = '{1023, 1,    1,    1023, 4};
        vecs[4] = '{0,    1024, 1024, 1023, 1027};
        vecs[5] = '{700,  2,    2,    701,  5};

        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};

        rst = 1'b1;
        repeat (3) tick;
        mon_en = 1;
        tick;
        rst = 1'b0;
        tick;

        // Table: full-throughput bursts, addresses, latency and done timing
        rmode = 0;
        for (int i = 0; i < 6; i++) begin
            clear_logs;
            pulse_start(vecs[i].base, vecs[i].len, s);
            wait_idle(3000);
            tick;
            chk("n_reads", addr_log.size(), vecs[i].nbeats);
            chk("n_beats", beat_cyc.size(), vecs[i].nbeats);
            if (addr_log.size() > 0)
                chk("last_addr", addr_log[addr_log.size()-1], vecs[i].last_addr);
            if (beat_cyc.size() > 0) begin
                chk("first_beat_lat", beat_cyc[0] - s, 3);
                chk("last_beat_lat", beat_cyc[beat_cyc.size()-1] - s, 2 + vecs[i].len);
            end
            chk("n_done", done_cyc.size(), 1);
            if (done_cyc.size() > 0) chk("done_lat", done_cyc[0] - s, vecs[i].done_off);
        end

        // Backpressure 1,0,0,1
        rmode = 1;
        clear_logs;
        pulse_start(100, 8, s);
        wait_idle(3000);
        tick;
        rmode = 0;
        chk("stall_beats", beat_cyc.size(), 8);
        chk("stall_done", done_cyc.size(), 1);

        // len=0 then a start pulsed while busy
        clear_logs;
        pulse_start(5, 0, s);
        tick;
        chk("len0_reads", addr_log.size(), 0);
        chk("len0_beats", beat_cyc.size(), 0);
        chk("len0_done_n", done_cyc.size(), 1);
        if (done_cyc.size() > 0) chk("len0_done_lat", done_cyc[0] - s, 1);
        clear_logs;
        pulse_start(200, 8, s);
        tick;
        pulse_start(300, 4, s2);
        wait_idle(3000);
        tick;
        chk("busy_start_reads", addr_log.size(), 8);
        if (addr_log.size() == 8) begin
            chk("busy_start_a0", addr_log[0], 200);
            chk("busy_start_a7", addr_log[7], 207);
        end
        chk("busy_start_done", done_cyc.size(), 1);

        // Reset on the 3rd beat of a 16-word burst, then a fresh 2-word burst
        clear_logs;
        pulse_start(40, 16, s);
        while (cyc < s + 5) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        repeat (6) tick;
        chk("abort_beats", beat_cyc.size(), 3);
        chk("abort_no_done", done_cyc.size(), 0);
        clear_logs;
        pulse_start(60, 2, s);
        wait_idle(3000);
        tick;
        chk("post_rst_beats", beat_cyc.size(), 2);
        chk("post_rst_done", done_cyc.size(), 1);

`ifdef BRAM_STREAM_RD_STRIDE_EN
        stride = ADDR'(3);
        want_addr[0] = ADDR'(0); want_addr[1] = ADDR'(3);
        want_addr[2] = ADDR'(6); want_addr[3] = ADDR'(9);
        clear_logs;
        pulse_start(0, 4, s);
        wait_idle(3000);
        tick;
        chk("stride_reads", addr_log.size(), 4);
        if (addr_log.size() == 4)
            for (int k = 0; k < 4; k++) chk("stride_addr", addr_log[k], want_addr[k]);
        stride = ADDR'(1);
`else
        want_addr[0] = '0; want_addr[1] = '0; want_addr[2] = '0; want_addr[3] = '0;
`endif

        // Random bursts with random backpressure and stray starts
        rmode = 2;
        for (int it = 0; it < 30; it++) begin
            b = $urandom_range(0, DEPTH - 1);
            l = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
`ifdef BRAM_STREAM_RD_STRIDE_EN
            stride = ADDR'($urandom_range(0, DEPTH - 1));
`endif
            pulse_start(b, l, s);
            if ($urandom_range(0, 2) == 0) begin
                tick;
                pulse_start($urandom_range(0, DEPTH - 1), $urandom_range(0, 12), s2);
            end
            wait_idle(3000);
            if ($urandom_range(0, 1) == 1) tick;
        end
        rmode = 0;
        wait_idle(3000);
        repeat (5) tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
